booth_multiplier_seq: RTL

Parametrised sequential radix-2 Booth multiplier. It is the next generation of the team's 8-bit shift/add multiplier datapath.
- Owns its own control FSM and a start/busy/done handshake.
- Produces a full 2*WIDTH-bit signed product.
- Sits between the operand registers and the result/display logic.
- Replaces the externally sequenced start_mult/shift/add/subtract control lines.

---
 rtl/booth_multiplier_seq_pkg.sv | 32 +++
 rtl/booth_multiplier_seq_if.sv | 38 +++
 rtl/booth_multiplier_seq_booth_step.sv | 30 +++
 rtl/booth_multiplier_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/booth_multiplier_seq_pkg.sv
// Shared types and sizing for the sequential radix-2 Booth multiplier.
// Used by booth_multiplier_seq and booth_step.
package mult_pkg;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;
  // One counter width covers every legal WIDTH, including the extra unsigned step.
  localparam int CNT_W = $clog2(WIDTH_MAX + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_t;

  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    booth_op_t op;
    case ({q0, q_1})
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_multiplier_seq_if.sv
// Start/busy/done handshake and operand/result bus of the Booth multiplier.
// MULT_UNSIGNED_SEL_EN adds the is_signed operand-mode select.
interface booth_multiplier_seq_if #(
  parameter int WIDTH = 8
);

  logic                   start;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     mult;
  logic                   sign;
`ifdef MULT_UNSIGNED_SEL_EN
  logic                   is_signed;

  modport master (
    output start, A, B, is_signed,
    input  busy, done, mult, sign
  );

  modport slave (
    input  start, A, B, is_signed,
    output busy, done, mult, sign
  );
`else
  modport master (
    output start, A, B,
    input  busy, done, mult, sign
  );

  modport slave (
    input  start, A, B,
    output busy, done, mult, sign
  );
`endif

endinterface

// File: rtl/booth_multiplier_seq_booth_step.sv
// One radix-2 Booth iteration: add/subtract A by {q[0],q_1}, then
// arithmetic-shift {acc,q,q_1} right by one.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH+1:0] p,
  input  logic [WIDTH:0]     a,
  output logic [2*WIDTH+1:0] p_next
);

  logic [WIDTH:0] acc_s;
  logic [WIDTH:0] sum_s;
  booth_op_t      op_s;

  // Booth add/subtract followed by the sign-replicating shift
  always_comb begin
    acc_s = p[2*WIDTH+1:WIDTH+1];
    op_s  = booth_decode(p[1], p[0]);
    case (op_s)
      ADD:     sum_s = acc_s + a;
      SUB:     sum_s = acc_s - a;
      NOP:     sum_s = acc_s;
      default: sum_s = acc_s;
    endcase
    p_next = {sum_s[WIDTH], sum_s, p[WIDTH:1]};
  end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier with its own IDLE/CALC/DONE control.
// Optional macro MULT_UNSIGNED_SEL_EN enables per-operation unsigned mode.
module booth_multiplier_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_multiplier_seq_if.slave bus
);

  localparam int PW = 2*WIDTH + 2;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("booth_multiplier_seq: WIDTH out of range");
  end

  mult_state_t          state_r;
  mult_state_t          state_next;
  logic [PW-1:0]        p_r;
  logic [PW-1:0]        p_next;
  logic [WIDTH:0]       a_r;
  logic [WIDTH:0]       a_next;
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     count_next;
  logic                 busy_r;
  logic                 busy_next;
  logic                 done_r;
  logic                 done_next;
  logic                 sign_r;
  logic                 sign_next;
  logic [2*WIDTH-1:0]   mult_r;
  logic [2*WIDTH-1:0]   mult_next;

  logic [PW-1:0]        step_in_s;
  logic [PW-1:0]        step_out_s;
  logic [PW-1:0]        step_res_s;
  logic                 ext_step_s;
  logic [WIDTH:0]       a_capture_s;
  logic [CNT_W-1:0]     count_load_s;
  logic [2*WIDTH-1:0]   product_s;

`ifdef MULT_UNSIGNED_SEL_EN
  logic signed_r;
  logic signed_next;

  // Operand extension, step count and product alignment for the captured mode
  always_comb begin
    if (bus.is_signed) begin
      a_capture_s  = {bus.A[WIDTH-1], bus.A};
      count_load_s = CNT_W'(WIDTH);
    end else begin
      a_capture_s  = {1'b0, bus.A};
      count_load_s = CNT_W'(WIDTH + 1);
    end
    // The unsigned run shifts once more, so its product sits one bit lower.
    if (signed_r) begin
      product_s = p_r[2*WIDTH:1];
    end else begin
      product_s = p_r[2*WIDTH-1:0];
    end
    if (state_r == CALC && !signed_r && count_r == CNT_W'(1)) begin
      ext_step_s = 1'b1;
    end else begin
      ext_step_s = 1'b0;
    end
    if (state_r == IDLE && bus.start) begin
      signed_next = bus.is_signed;
    end else begin
      signed_next = signed_r;
    end
  end

  // Operand-mode register, captured with A and B
  always_ff @(posedge clk) begin
    if (rst) begin
      signed_r <= 1'b1;
    end else begin
      signed_r <= signed_next;
    end
  end
`else
  // Always-signed operand extension and product alignment
  always_comb begin
    a_capture_s  = {bus.A[WIDTH-1], bus.A};
    count_load_s = CNT_W'(WIDTH);
    product_s    = p_r[2*WIDTH:1];
    ext_step_s   = 1'b0;
  end
`endif

  // Final unsigned step decodes the zero extension bit, not the product LSB in q[0]
  always_comb begin
    if (ext_step_s) begin
      step_in_s = {p_r[PW-1:2], 1'b0, p_r[0]};
    end else begin
      step_in_s = p_r;
    end
  end

  booth_step #(
    .WIDTH (WIDTH)
  ) u_booth_step (
    .p      (step_in_s),
    .a      (a_r),
    .p_next (step_out_s)
  );

  // Restore the real q[0] into q_1 after the forced-decode step
  always_comb begin
    if (ext_step_s) begin
      step_res_s = {step_out_s[PW-1:1], p_r[1]};
    end else begin
      step_res_s = step_out_s;
    end
  end

  // Next-state and next-output logic of the control FSM
  always_comb begin
    state_next = state_r;
    p_next     = p_r;
    a_next     = a_r;
    count_next = count_r;
    busy_next  = busy_r;
    done_next  = 1'b0;
    mult_next  = mult_r;
    sign_next  = sign_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          a_next     = a_capture_s;
          p_next     = {{(WIDTH+1){1'b0}}, bus.B, 1'b0};
          count_next = count_load_s;
          busy_next  = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        p_next     = step_res_s;
        count_next = count_r - CNT_W'(1);
        if (count_r == CNT_W'(1)) begin
          state_next = DONE;
        end else begin
          state_next = CALC;
        end
      end
      DONE: begin
        mult_next  = product_s;
        sign_next  = product_s[2*WIDTH-1];
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered-output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      p_r     <= {PW{1'b0}};
      a_r     <= {(WIDTH+1){1'b0}};
      count_r <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      mult_r  <= {(2*WIDTH){1'b0}};
      sign_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      p_r     <= p_next;
      a_r     <= a_next;
      count_r <= count_next;
      busy_r  <= busy_next;
      done_r  <= done_next;
      mult_r  <= mult_next;
      sign_r  <= sign_next;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.mult = mult_r;
  assign bus.sign = sign_r;

endmodule
